// File: rtl/checkout_totalizer.sv
// rtl/checkout_totalizer.sv - per-sale price/item accumulator fed by the product lookup results
module checkout_totalizer #(
    parameter int TOT_W     = 10,
    parameter int MAX_ITEMS = 31
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             item_valid,
    input  logic             close,
    input  logic [3:0]       P,
    input  logic [1:0]       V,
    input  logic [11:0]      QR,
    output logic [TOT_W-1:0] total,
    output logic [4:0]       item_count,
    output logic [4:0]       today_count,
    output logic [4:0]       expired_count,
    output logic [4:0]       reject_count,
    output logic [2:0]       last_code,
    output logic             busy,
    output logic             full,
    output logic             ovf,
    output logic             sale_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPEN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] MAX_CNT = 5'(MAX_ITEMS);

    state_t           state_q, state_d;
    logic [TOT_W-1:0] total_q, total_d;
    logic [4:0]       item_count_q, item_count_d;
    logic [4:0]       today_count_q, today_count_d;
    logic [4:0]       expired_count_q, expired_count_d;
    logic [4:0]       reject_count_q, reject_count_d;
    logic [2:0]       last_code_q, last_code_d;
    logic             ovf_q, ovf_d;
    logic             sale_done_q, sale_done_d;

    logic             start_sale;
    logic             take_item;
    logic [3:0]       addend;
    logic [TOT_W:0]   sum;

    // Only the product code is kept; the date fields are consumed upstream.
    logic unused_qr_date;
    assign unused_qr_date = ^QR[11:3];

    function automatic logic [4:0] sat_inc(input logic [4:0] c);
        return (c == 5'd31) ? c : c + 5'd1;
    endfunction

    // Next-state and sale bookkeeping: a new sale is cleared first, then the item applied on top.
    always_comb begin
        state_d         = state_q;
        total_d         = total_q;
        item_count_d    = item_count_q;
        today_count_d   = today_count_q;
        expired_count_d = expired_count_q;
        reject_count_d  = reject_count_q;
        last_code_d     = last_code_q;
        ovf_d           = ovf_q;
        sale_done_d     = 1'b0;
        start_sale      = 1'b0;
        take_item       = 1'b0;
        addend          = 4'd0;
        sum             = '0;

        case (state_q)
            S_IDLE: begin
                if (item_valid) begin
                    start_sale = 1'b1;
                    take_item  = 1'b1;
                    state_d    = S_OPEN;
                end
            end
            S_OPEN: begin
                take_item = item_valid;
                if (close) begin
                    state_d     = S_DONE;
                    sale_done_d = 1'b1;
                end
            end
            S_DONE: begin
                if (item_valid) begin
                    start_sale = 1'b1;
                    take_item  = 1'b1;
                    if (close) begin
                        state_d     = S_DONE;
                        sale_done_d = 1'b1;
                    end else begin
                        state_d = S_OPEN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start_sale) begin
            total_d         = '0;
            item_count_d    = 5'd0;
            today_count_d   = 5'd0;
            expired_count_d = 5'd0;
            reject_count_d  = 5'd0;
            last_code_d     = 3'd0;
            ovf_d           = 1'b0;
        end

        if (take_item) begin
            case (V)
                2'b10, 2'b01: begin
                    // Once the sale is full, billable items vanish without trace.
                    if (item_count_d < MAX_CNT) begin
                        addend = (V == 2'b10) ? P : (P >> 1);
                        sum    = {1'b0, total_d} + {{(TOT_W-3){1'b0}}, addend};
                        if (sum[TOT_W]) begin
                            total_d = '1;
                            ovf_d   = 1'b1;
                        end else begin
                            total_d = sum[TOT_W-1:0];
                        end
                        item_count_d = sat_inc(item_count_d);
                        if (V == 2'b01) begin
                            today_count_d = sat_inc(today_count_d);
                        end
                        last_code_d = QR[2:0];
                    end
                end
                2'b00:   expired_count_d = sat_inc(expired_count_d);
                default: reject_count_d  = sat_inc(reject_count_d);
            endcase
        end
    end

    // State and sale registers; clr discards any sale in progress.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q         <= S_IDLE;
            total_q         <= '0;
            item_count_q    <= 5'd0;
            today_count_q   <= 5'd0;
            expired_count_q <= 5'd0;
            reject_count_q  <= 5'd0;
            last_code_q     <= 3'd0;
            ovf_q           <= 1'b0;
            sale_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            total_q         <= total_d;
            item_count_q    <= item_count_d;
            today_count_q   <= today_count_d;
            expired_count_q <= expired_count_d;
            reject_count_q  <= reject_count_d;
            last_code_q     <= last_code_d;
            ovf_q           <= ovf_d;
            sale_done_q     <= sale_done_d;
        end
    end

    assign total         = total_q;
    assign item_count    = item_count_q;
    assign today_count   = today_count_q;
    assign expired_count = expired_count_q;
    assign reject_count  = reject_count_q;
    assign last_code     = last_code_q;
    assign ovf           = ovf_q;
    assign sale_done     = sale_done_q;
    assign busy          = (state_q == S_OPEN);
    assign full          = (item_count_q >= MAX_CNT);

endmodule

// File: tb/tb_checkout_totalizer.sv
// tb/tb_checkout_totalizer.sv - vector table plus scoreboard bench for checkout_totalizer
module tb_checkout_totalizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr;

    logic        iv_a, cl_a;
    logic [3:0]  p_a;
    logic [1:0]  v_a;
    logic [11:0] qr_a;
    logic [9:0]  tot_a;
    logic [4:0]  ic_a, tc_a, ec_a, rc_a;
    logic [2:0]  lc_a;
    logic        b_a, f_a, o_a, d_a;

    logic        iv_b, cl_b;
    logic [3:0]  p_b;
    logic [1:0]  v_b;
    logic [11:0] qr_b;
    logic [5:0]  tot_b;
    logic [4:0]  ic_b, tc_b, ec_b, rc_b;
    logic [2:0]  lc_b;
    logic        b_b, f_b, o_b, d_b;

    checkout_totalizer #(.TOT_W(10), .MAX_ITEMS(31)) dut_a (
        .clk(clk), .clr(clr), .item_valid(iv_a), .close(cl_a),
        .P(p_a), .V(v_a), .QR(qr_a),
        .total(tot_a), .item_count(ic_a), .today_count(tc_a),
        .expired_count(ec_a), .reject_count(rc_a), .last_code(lc_a),
        .busy(b_a), .full(f_a), .ovf(o_a), .sale_done(d_a)
    );

    checkout_totalizer #(.TOT_W(6), .MAX_ITEMS(31)) dut_b (
        .clk(clk), .clr(clr), .item_valid(iv_b), .close(cl_b),
        .P(p_b), .V(v_b), .QR(qr_b),
        .total(tot_b), .item_count(ic_b), .today_count(tc_b),
        .expired_count(ec_b), .reject_count(rc_b), .last_code(lc_b),
        .busy(b_b), .full(f_b), .ovf(o_b), .sale_done(d_b)
    );

    typedef struct {
        bit          d6;
        logic        iv, cl;
        logic [3:0]  p;
        logic [1:0]  v;
        logic [11:0] qr;
        logic [9:0]  tot;
        logic [4:0]  ic, tc, ec, rc;
        logic [2:0]  lc;
        logic        b, f, o, d;
    } vec_t;

    typedef struct {
        bit          d6;
        logic [36:0] e;
        int          id;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(bit d6, bit iv, bit cl, int p, int v, int qr,
                                int tot, int ic, int tc, int ec, int rc, int lc,
                                bit b, bit f, bit o, bit d);
        vec_t r;
        r.d6 = d6; r.iv = iv; r.cl = cl;
        r.p = 4'(p); r.v = 2'(v); r.qr = 12'(qr);
        r.tot = 10'(tot); r.ic = 5'(ic); r.tc = 5'(tc); r.ec = 5'(ec); r.rc = 5'(rc);
        r.lc = 3'(lc); r.b = b; r.f = f; r.o = o; r.d = d;
        return r;
    endfunction

    function automatic logic [36:0] exp_pack(vec_t r);
        return {r.tot, r.ic, r.tc, r.ec, r.rc, r.lc, r.b, r.f, r.o, r.d};
    endfunction

    function automatic logic [36:0] act_pack(bit d6);
        if (d6) return {4'd0, tot_b, ic_b, tc_b, ec_b, rc_b, lc_b, b_b, f_b, o_b, d_b};
        return {tot_a, ic_a, tc_a, ec_a, rc_a, lc_a, b_a, f_a, o_a, d_a};
    endfunction

    function automatic string fmt(logic [36:0] x);
        return $sformatf("tot=%0d items=%0d today=%0d exp=%0d rej=%0d last=%0d busy=%0b full=%0b ovf=%0b done=%0b",
                         x[36:27], x[26:22], x[21:17], x[16:12], x[11:7], x[6:4], x[3], x[2], x[1], x[0]);
    endfunction

    task automatic check(input int id, input logic [36:0] act, input logic [36:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step%0d: got {%s} expected {%s}", id, fmt(act), fmt(exp));
        end
    endtask

    task automatic apply(input vec_t r, input int id);
        sb_t s;
        @(negedge clk);
        if (r.d6) begin
            iv_b = r.iv; cl_b = r.cl; p_b = r.p; v_b = r.v; qr_b = r.qr;
        end else begin
            iv_a = r.iv; cl_a = r.cl; p_a = r.p; v_a = r.v; qr_a = r.qr;
        end
        sb_q.push_back('{r.d6, exp_pack(r), id});
        @(posedge clk);
        #2;
        iv_a = 1'b0; cl_a = 1'b0; iv_b = 1'b0; cl_b = 1'b0;
        s = sb_q.pop_front();
        check(s.id, act_pack(s.d6), s.e);
    endtask

    initial begin
        clr = 1'b1;
        iv_a = 0; cl_a = 0; p_a = 0; v_a = 0; qr_a = 0;
        iv_b = 0; cl_b = 0; p_b = 0; v_b = 0; qr_b = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) clr = 1'b0;

        // reset state, close in IDLE, expired-only sale
        tbl.push_back(mk(0,0,0, 0,0,0,      0,0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,1, 0,0,0,      0,0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 9,0,'h000,  0,0,0,1,0,0, 1,0,0,0));
        tbl.push_back(mk(0,1,0, 9,0,'h000,  0,0,0,2,0,0, 1,0,0,0));
        tbl.push_back(mk(0,0,1, 0,0,0,      0,0,0,2,0,0, 0,0,0,1));
        tbl.push_back(mk(0,0,0, 0,0,0,      0,0,0,2,0,0, 0,0,0,0));
        // basic four-item sale, started from DONE
        tbl.push_back(mk(0,1,0,10,2,'hFE2, 10,1,0,0,0,2, 1,0,0,0));
        tbl.push_back(mk(0,1,0,15,1,'hC95, 17,2,1,0,0,5, 1,0,0,0));
        tbl.push_back(mk(0,1,0, 4,2,'hD11, 21,3,1,0,0,1, 1,0,0,0));
        tbl.push_back(mk(0,1,0, 0,3,'h007, 21,3,1,0,1,1, 1,0,0,0));
        tbl.push_back(mk(0,0,1, 0,0,0,     21,3,1,0,1,1, 0,0,0,1));
        tbl.push_back(mk(0,0,0, 0,0,0,     21,3,1,0,1,1, 0,0,0,0));
        // item+close in OPEN, then item+close in DONE
        tbl.push_back(mk(0,1,0, 3,2,'h003,  3,1,0,0,0,3, 1,0,0,0));
        tbl.push_back(mk(0,1,1, 6,2,'h004,  9,2,0,0,0,4, 0,0,0,1));
        tbl.push_back(mk(0,1,1, 5,1,'h006,  2,1,1,0,0,6, 0,0,0,1));
        tbl.push_back(mk(0,0,0, 0,0,0,      2,1,1,0,0,6, 0,0,0,0));
        // 6-bit total saturation, ovf cleared by next sale
        tbl.push_back(mk(1,0,0, 0,0,0,      0,0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,1,0,15,2,'h001, 15,1,0,0,0,1, 1,0,0,0));
        tbl.push_back(mk(1,1,0,15,2,'h001, 30,2,0,0,0,1, 1,0,0,0));
        tbl.push_back(mk(1,1,0,15,2,'h001, 45,3,0,0,0,1, 1,0,0,0));
        tbl.push_back(mk(1,1,0,15,2,'h001, 60,4,0,0,0,1, 1,0,0,0));
        tbl.push_back(mk(1,1,0,15,2,'h001, 63,5,0,0,0,1, 1,0,1,0));
        tbl.push_back(mk(1,0,1, 0,0,0,     63,5,0,0,0,1, 0,0,1,1));
        tbl.push_back(mk(1,1,0, 1,2,'h002,  1,1,0,0,0,2, 1,0,0,0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // 33 fresh items: the last two must vanish
        for (int i = 1; i <= 33; i++) begin
            int n;
            n = (i > 31) ? 31 : i;
            apply(mk(0,1,0, 1,2,0, n,n,0,0,0,0, 1,(i >= 31),0,0), 100 + i);
        end
        apply(mk(0,1,0, 1,0,0, 31,31,0,1,0,0, 1,1,0,0), 140);
        apply(mk(0,0,1, 0,0,0, 31,31,0,1,0,0, 0,1,0,1), 141);

        // asynchronous clear mid-sale
        apply(mk(0,1,0, 2,2,'h001, 2,1,0,0,0,1, 1,0,0,0), 200);
        apply(mk(0,1,0, 2,2,'h001, 4,2,0,0,0,1, 1,0,0,0), 201);
        #1 clr = 1'b1;
        #1;
        check(300, act_pack(0), 37'd0);
        check(301, act_pack(1), 37'd0);
        #2 clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(302 + i, {35'd0, d_a, b_a}, 37'd0);
        end
        apply(mk(0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0,0,0), 310);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/checkout_totalizer.md
# checkout_totalizer

Sale accumulator on the consumer side of the product lookup circuit. It takes the per-item results `P`, `V` and `QR` and builds a running sale from them. It keeps the price total, item counts by freshness class and the last accepted code, and reports a closed sale with a one-cycle done pulse.

## Interface
- `TOT_W`, 10: width of the `total` accumulator, in dollars.
- `MAX_ITEMS`, 31: maximum number of items per sale. Must fit in 5 bits.
- `clk`, in, 1: system clock. All state changes on the rising edge.
- `clr`, in, 1: reset. One clock; reset is asynchronous and active-high.
- `item_valid`, in, 1: `P`/`V`/`QR` hold one scanned item this cycle.
- `close`, in, 1: end of sale request.
- `P`, in, 4: item price in dollars, 0–15.
- `V`, in, 2: freshness class.
  - 2'b10: fresh.
  - 2'b01: expires on the reference date.
  - 2'b00: expired.
  - 2'b11: unassigned code.
- `QR`, in, 12: item word as {day[4:0], month[3:0], code[2:0]}.
- `total`, out, TOT_W: accumulated sale amount.
- `item_count`, out, 5: items accepted (fresh plus today).
- `today_count`, out, 5: accepted items billed at the discounted price.
- `expired_count`, out, 5: items refused as expired.
- `reject_count`, out, 5: items refused as unassigned.
- `last_code`, out, 3: `QR[2:0]` of the last accepted item.
- `busy`, out, 1: sale open.
- `full`, out, 1: `item_count` has reached `MAX_ITEMS`.
- `ovf`, out, 1: sticky; total saturated during this sale.
- `sale_done`, out, 1: one-cycle pulse when a sale closes.

## Operation
- FSM states: IDLE, OPEN, DONE.
- IDLE:
  - `item_valid` clears all counters and `ovf`, processes the item, and goes to OPEN.
  - `close` alone is ignored.
- OPEN:
  - Each `item_valid` cycle processes one item.
  - `close` goes to DONE. If `item_valid` is also high that cycle, the item is processed first, in the same edge.
- DONE:
  - Counters, `total`, `last_code` and `ovf` are held for readout.
  - `item_valid` starts a new sale exactly as from IDLE and goes to OPEN.
  - If `close` is also high, the new one-item sale closes immediately: state stays DONE and `sale_done` pulses again.
- Item processing by `V`:
  - 2'b10: add `P`, `item_count`+1, `last_code` ← `QR[2:0]`.
  - 2'b01: add `P>>1` (floor), `item_count`+1, `today_count`+1, `last_code` ← `QR[2:0]`.
  - 2'b00: `expired_count`+1. No change to the total.
  - 2'b11: `reject_count`+1. No change to the total.
- Addition:
  - Performed at TOT_W+1 bits.
  - If the result exceeds 2^TOT_W−1, `total` saturates at all-ones and `ovf` sets. `ovf` stays set until a new sale starts.
- Item limit:
  - When `full` is high, further fresh/today items are dropped and not counted anywhere.
  - Expired and reject counts still increment, saturating at 31.
- All counters saturate at 31. None of them wrap.

## Timing
- All outputs are registered. An item sampled at edge k is visible in the outputs after edge k.
- `busy` is high in OPEN only.
- `sale_done` is high for the single cycle following the edge that enters DONE, including a DONE→DONE re-close.
- `full` updates in the same cycle as `item_count`.
- Reset is asynchronous and active-high:
  - State → IDLE.
  - `total` = 0, all counts = 0, `last_code` = 0.
  - `busy` = `full` = `ovf` = `sale_done` = 0.
- Reset asserted mid-sale discards the sale. No `sale_done` is produced.
- There is no backpressure. One item per cycle is sustained indefinitely.

## Test plan
- Basic sale of four items with one cycle each, then `close`. Required result: `total`=21, `item_count`=3, `today_count`=1, `reject_count`=1, `last_code`=1, one `sale_done` pulse, `busy` low afterwards.
  - P=10, V=10, QR=12'hFE2.
  - P=15, V=01, QR=12'hC95.
  - P=4, V=10, QR=12'hD11.
  - P=0, V=11, QR=12'h007.
- Expired only: two items with P=9, V=00, then `close`. Required result: `total`=0, `expired_count`=2, `item_count`=0.
- Overflow with TOT_W=6: five fresh items with P=15. Required result: `total`=63, `ovf`=1. The next sale, started from DONE, reads `ovf`=0.
- Full: 33 fresh items with P=1. Required result: `item_count`=31, `total`=31, `full`=1. Items 32 and 33 are ignored.
- Simultaneous events:
  - `item_valid` and `close` together in OPEN: the item is included in `total`.
  - The same pair in DONE: `total` equals that one item and `sale_done` pulses.
  - `close` in IDLE: no response.
- Reset mid-sale: `clr` pulses asynchronously between edges after two items. All outputs read 0 immediately, and no `sale_done` pulse occurs.
